// File: rtl/demux_1x4_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux_1x4_reg
// Description : Registered 1-to-4 valid/ready demultiplexer. Each channel has
//               its own one-entry holding register and handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_1x4_reg #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [15:0]        acc_cnt
);

    localparam int c_NCH = 4;

    logic [c_NCH-1:0]            hold_vld_q;
    logic [c_NCH-1:0]            hold_vld_d;
    logic [c_NCH-1:0][WIDTH-1:0] hold_data_q;
    logic [c_NCH-1:0][WIDTH-1:0] hold_data_d;
    logic [15:0]                 acc_cnt_q;
    logic [15:0]                 acc_cnt_d;
    logic                        w_in_xfer;

    // A full slot that drains on this edge can take a new word on the same edge.
    assign in_ready  = !hold_vld_q[in_sel] || out_ready[in_sel];
    assign w_in_xfer = in_valid && in_ready;

    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        acc_cnt_d   = acc_cnt_q;
        for (int i = 0; i < c_NCH; i++) begin
            if (hold_vld_q[i] && out_ready[i]) begin
                hold_vld_d[i] = 1'b0;
            end
        end
        // Write after drain so a same-edge reload keeps the slot valid.
        if (w_in_xfer) begin
            hold_vld_d[in_sel]  = 1'b1;
            hold_data_d[in_sel] = in_data;
            acc_cnt_d           = acc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q  <= '0;
            hold_data_q <= '0;
            acc_cnt_q   <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

    // Packed array flattens with channel 0 in the least significant slice.
    assign out_data  = hold_data_q;
    assign out_valid = hold_vld_q;
    assign acc_cnt   = acc_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_1x4_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_1x4_reg
// Description : Scoreboard bench for demux_1x4_reg with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1x4_reg;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [WIDTH-1:0]   in_data = '0;
    logic [1:0]         in_sel = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready = 4'b0000;
    logic [15:0]        acc_cnt;

    logic [7:0]  exp_q [4][$];
    logic [15:0] exp_cnt = 16'd0;
    int          n_vec = 0;
    int          n_fail = 0;
    logic [7:0]  mon_exp;

    demux_1x4_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_cnt   (acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a word, wait (bounded) for acceptance, return at posedge+1.
    task automatic send(input logic [7:0] d, input logic [1:0] s);
        int  waits;
        bit  ok;
        waits = 0;
        ok    = 1'b0;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        while (!ok) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
            end else begin
                waits++;
                if (waits > 50) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL send_timeout: word 0x%0h sel %0d never accepted, required acceptance", d, s);
                    break;
                end
            end
        end
        if (ok) begin
            exp_q[s].push_back(d);
            exp_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the head of its channel queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    n_vec++;
                    if (exp_q[i].size() == 0) begin
                        n_fail++;
                        $display("FAIL mon_ch%0d: got unexpected word 0x%0h, required none", i, out_data[i*8 +: 8]);
                    end else begin
                        mon_exp = exp_q[i].pop_front();
                        if (out_data[i*8 +: 8] !== mon_exp) begin
                            n_fail++;
                            $display("FAIL mon_ch%0d: got 0x%0h, expected 0x%0h", i, out_data[i*8 +: 8], mon_exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bdat [4];
        bdat[0] = 8'hA0; bdat[1] = 8'hB1; bdat[2] = 8'hC2; bdat[3] = 8'hD3;

        // Reset state before any clock edge
        #3;
        check("rst_out_valid", out_valid, 4'b0000);
        check("rst_out_data", out_data, 32'h0);
        check("rst_acc_cnt", acc_cnt, 16'h0);
        check("rst_in_ready", in_ready, 1'b1);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic routing
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            send(bdat[i], 2'(i));
            check("basic_valid_pulse", out_valid, 32'(4'b0001 << i));
            check("basic_data", out_data[i*8 +: 8], bdat[i]);
        end
        idle(1);
        check("basic_drained", out_valid, 4'b0000);
        check("basic_acc_cnt", acc_cnt, 16'd4);

        // Back-pressure on channel 1
        out_ready = 4'b1101;
        send(8'h11, 2'd1);
        check("bp_hold_valid", out_valid, 4'b0010);
        in_data = 8'h22; in_sel = 2'd1; in_valid = 1'b1;
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_in_ready_still_low", in_ready, 1'b0);
        check("bp_data_stable", out_data[15:8], 8'h11);
        @(posedge clk); #1;
        in_valid = 1'b0;
        send(8'h33, 2'd3);
        check("bp_other_channel", out_valid, 4'b1010);
        check("bp_ch3_data", out_data[31:24], 8'h33);
        out_ready = 4'b1111;
        send(8'h22, 2'd1);
        check("bp_reload_valid", out_valid, 4'b0010);
        check("bp_reload_data", out_data[15:8], 8'h22);
        idle(2);

        // Same-edge reload on channel 0
        out_ready = 4'b1110;
        send(8'h55, 2'd0);
        check("reload_hold", out_valid, 4'b0001);
        out_ready = 4'b1111;
        send(8'h66, 2'd0);
        check("reload_valid", out_valid[0], 1'b1);
        check("reload_data", out_data[7:0], 8'h66);
        check("reload_acc_cnt", acc_cnt, exp_cnt);
        idle(2);

        // Drain channel 2 while writing channel 3
        out_ready = 4'b0011;
        send(8'h77, 2'd2);
        out_ready = 4'b0111;
        send(8'h88, 2'd3);
        check("concur_valid", out_valid, 4'b1000);
        check("concur_data", out_data[31:24], 8'h88);
        out_ready = 4'b1111;
        idle(2);
        check("concur_drained", out_valid, 4'b0000);

        // Counter wrap
        while (exp_cnt != 16'hFFFF) send(exp_cnt[7:0], exp_cnt[1:0]);
        check("wrap_ffff", acc_cnt, 16'hFFFF);
        send(8'hE7, 2'd2);
        check("wrap_zero", acc_cnt, 16'h0000);
        check("wrap_route_valid", out_valid, 4'b0100);
        check("wrap_route_data", out_data[23:16], 8'hE7);
        idle(2);

        // Asynchronous reset with channels 0 and 2 full
        out_ready = 4'b0000;
        send(8'h5A, 2'd0);
        send(8'hA5, 2'd2);
        check("prerst_valid", out_valid, 4'b0101);
        check("prerst_in_ready", in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        exp_cnt = 16'd0;
        #1;
        check("arst_out_valid", out_valid, 4'b0000);
        check("arst_out_data", out_data, 32'h0);
        check("arst_acc_cnt", acc_cnt, 16'h0);
        check("arst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 4'b1111;
        send(8'h3C, 2'd1);
        check("postrst_acc_cnt", acc_cnt, 16'd1);
        check("postrst_valid", out_valid, 4'b0010);
        idle(2);

        for (int i = 0; i < 4; i++) check("queue_empty", 32'(exp_q[i].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_1x4_reg.md
# demux_1x4_reg

Registered 1-to-4 demultiplexer for valid/ready streams: the distribution-side counterpart to the 2:1 select mux. A single input stream carries a 2-bit channel select with each word, and the block steers every accepted word into a one-entry holding register for the selected output channel. Each channel then presents its word with its own valid/ready handshake. It sits between a shared producer and four independent consumers, and decouples consumer back-pressure per channel.

## Interface
Parameters:
- WIDTH, 8, data width of each word.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination channel, 0..3; qualified by in_valid.
- in_valid  input  1  input word and select are valid.
- in_ready  output  1  block accepts input this cycle.
- out_data  output  4*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  4  per-channel valid.
- out_ready  input  4  per-channel consumer ready.
- acc_cnt  output  16  count of accepted input words; wraps 0xFFFF->0x0000.

## Operation
- Per channel i: holding register hold_data[i] (WIDTH bits) and flag hold_vld[i]; out_data slice i = hold_data[i]; out_valid[i] = hold_vld[i].
- in_ready = !hold_vld[in_sel] || out_ready[in_sel]. This is combinational from in_sel, hold_vld and out_ready, so a full slot being drained this cycle accepts a new word in the same cycle.
- Input transfer: in_valid && in_ready at the clock edge.
  - hold_data[in_sel] <= in_data.
  - hold_vld[in_sel] <= 1.
  - acc_cnt <= acc_cnt + 1.
- Output transfer on channel i: out_valid[i] && out_ready[i] at the clock edge. This clears hold_vld[i] unless the same edge writes channel i.
- Write and drain on the same channel, same edge: slot reloads with the new word; hold_vld stays 1.
- Write to channel j and drain of channel k≠j on the same edge: both take effect independently.
- Channels drain independently. Ordering is preserved within a channel (depth 1). Ordering across channels is not guaranteed.
- A stalled channel blocks input only for words selected to that channel. Words for other channels pass unaffected.
- While out_valid[i]=1 and out_ready[i]=0, out_data slice i holds stable.
- in_data and in_sel are ignored when in_valid=0. in_ready is still driven from in_sel.
- Reset (rst_n low, asynchronous): hold_vld=0, hold_data=0, acc_cnt=0.
  - Outputs during and after reset: out_valid=4'b0000, out_data=0, acc_cnt=0.
  - in_ready=1, because all slots are empty.
  - Reset asserted mid-transfer discards all held words; no partial state survives.

## Timing
- Latency: a word accepted at edge N appears at out_valid/out_data of its channel after edge N, so it is visible in cycle N+1.
- Throughput: 1 word/cycle sustained to any channel whose consumer holds out_ready=1.
- Throughput to a single channel with out_ready=1 every cycle: 1 word/cycle, via the same-edge reload.
- Combinational paths: in_sel/out_ready -> in_ready only. No combinational path from in_data or in_valid to any output.
- Outputs out_valid, out_data and acc_cnt are registered.
- rst_n deassertion is synchronised externally. The block requires only that rst_n rises away from a clk edge.

## Test plan
- Reset: assert rst_n=0 mid-stream with channels 0 and 2 full -> out_valid=0000, out_data=0, acc_cnt=0, in_ready=1 immediately, without waiting for a clock.
- Basic routing, out_ready=1111:
  - Stimulus: send 0xA0 sel0, 0xB1 sel1, 0xC2 sel2, 0xD3 sel3 on consecutive cycles.
  - Response: each word appears one cycle later on only its channel with a single-cycle out_valid pulse; acc_cnt=4.
- Back-pressure:
  - Stimulus: out_ready[1]=0; send 0x11 sel1, then 0x22 sel1, then 0x33 sel3.
  - Response: 0x11 held on channel 1. in_ready=0 while 0x22 is presented, so 0x22 stalls. After 0x22 is withdrawn, 0x33 is accepted on channel 3. Raising out_ready[1] drains 0x11, then 0x22 is accepted.
- Same-edge reload:
  - Stimulus: channel 0 holds 0x55, out_ready[0]=1; send 0x66 sel0 in the same cycle.
  - Response: out_valid[0] stays 1 and data becomes 0x66 next cycle; acc_cnt increments by 1.
- Concurrent write/drain on different channels:
  - Stimulus: drain channel 2 (0x77) while writing 0x88 sel3.
  - Response: out_valid=1000 with data 0x88 next cycle.
- Counter wrap:
  - Stimulus: preload via 65535 accepted words, then send one more.
  - Response: acc_cnt goes 0xFFFF -> 0x0000; routing is unaffected.
